// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : issue_ctrl
//  Description : In-order issue controller. Pops the fetch queue, allocates
//                ROB tags, steers instructions to the RS or LSB, serialises
//                JALR and sequences flush recovery.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_ctrl #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fq_valid,
    input  logic [31:0]      fq_inst,
    input  logic [31:0]      fq_pc,
    output logic             fq_pop,
    input  logic             rs_full,
    input  logic             lsb_full,
    input  logic             commit_valid,
    input  logic             flush,
    input  logic             jalr_done,
    output logic             dec_ena,
    output logic [31:0]      dec_inst,
    output logic [31:0]      dec_pc,
    output logic [TAG_W-1:0] dec_tag,
    output logic             rs_issue,
    output logic             lsb_issue,
    output logic             rob_full
);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_WAIT_JALR = 2'd1,
        S_FLUSH     = 2'd2
    } state_t;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_OP    = 7'b0110011;
    localparam logic [6:0] c_OP_OPIMM = 7'b0010011;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;

    // Highest usable tag; tag 0 is reserved as "no tag"
    localparam logic [TAG_W-1:0] c_TAG_MAX = TAG_W'(ROB_SIZE - 1);
    localparam logic [TAG_W-1:0] c_TAG_ONE = TAG_W'(1);

    state_t             state_q,     state_d;
    logic [TAG_W-1:0]   count_q,     count_d;
    logic [TAG_W-1:0]   next_tag_q,  next_tag_d;
    logic               dec_ena_q,   dec_ena_d;
    logic [31:0]        dec_inst_q,  dec_inst_d;
    logic [31:0]        dec_pc_q,    dec_pc_d;
    logic [TAG_W-1:0]   dec_tag_q,   dec_tag_d;
    logic               rs_issue_q,  rs_issue_d;
    logic               lsb_issue_q, lsb_issue_d;

    logic w_is_lsb;
    logic w_is_rs;
    logic w_is_jalr;
    logic w_legal;
    logic w_run_head;
    logic w_unit_full;
    logic w_issue;
    logic w_commit;

    // Decode the head opcode into its target unit
    always_comb begin
        w_is_lsb  = 1'b0;
        w_is_rs   = 1'b0;
        w_is_jalr = 1'b0;
        case (fq_inst[6:0])
            c_OP_LOAD, c_OP_STORE: w_is_lsb = 1'b1;
            c_OP_LUI, c_OP_AUIPC, c_OP_JAL,
            c_OP_BR, c_OP_OP, c_OP_OPIMM: w_is_rs = 1'b1;
            c_OP_JALR: begin
                w_is_rs   = 1'b1;
                w_is_jalr = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_legal     = w_is_lsb | w_is_rs;
    assign w_run_head  = (state_q == S_RUN) && fq_valid && !flush;
    assign w_unit_full = w_is_lsb ? lsb_full : rs_full;
    assign rob_full    = (count_q == c_TAG_MAX);
    assign w_issue     = w_run_head && w_legal && !rob_full && !w_unit_full;
    // A commit against an empty ROB is meaningless and is dropped
    assign w_commit    = commit_valid && (count_q != '0);
    // Illegal opcodes are popped and discarded regardless of back-pressure
    assign fq_pop      = !rst && w_run_head && (w_issue || !w_legal);

    // Next-state, tag/count bookkeeping and decode-stage outputs
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        next_tag_d  = next_tag_q;
        dec_ena_d   = w_issue;
        rs_issue_d  = w_issue && w_is_rs;
        lsb_issue_d = w_issue && w_is_lsb;
        dec_inst_d  = dec_inst_q;
        dec_pc_d    = dec_pc_q;
        dec_tag_d   = dec_tag_q;

        if (w_issue) begin
            dec_inst_d = fq_inst;
            dec_pc_d   = fq_pc;
            dec_tag_d  = next_tag_q;
            next_tag_d = (next_tag_q == c_TAG_MAX) ? c_TAG_ONE : next_tag_q + c_TAG_ONE;
        end

        case ({w_issue, w_commit})
            2'b10:   count_d = count_q + c_TAG_ONE;
            2'b01:   count_d = count_q - c_TAG_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_RUN:       if (w_issue && w_is_jalr) state_d = S_WAIT_JALR;
            S_WAIT_JALR: if (jalr_done) state_d = S_RUN;
            S_FLUSH:     state_d = S_RUN;
            default:     state_d = S_RUN;
        endcase

        // Flush wins over everything: empty the ROB view and restart tags
        if (flush) begin
            state_d     = S_FLUSH;
            count_d     = '0;
            next_tag_d  = c_TAG_ONE;
            dec_ena_d   = 1'b0;
            rs_issue_d  = 1'b0;
            lsb_issue_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            count_q     <= '0;
            next_tag_q  <= c_TAG_ONE;
            dec_ena_q   <= 1'b0;
            dec_inst_q  <= '0;
            dec_pc_q    <= '0;
            dec_tag_q   <= '0;
            rs_issue_q  <= 1'b0;
            lsb_issue_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            next_tag_q  <= next_tag_d;
            dec_ena_q   <= dec_ena_d;
            dec_inst_q  <= dec_inst_d;
            dec_pc_q    <= dec_pc_d;
            dec_tag_q   <= dec_tag_d;
            rs_issue_q  <= rs_issue_d;
            lsb_issue_q <= lsb_issue_d;
        end
    end

    assign dec_ena   = dec_ena_q;
    assign dec_inst  = dec_inst_q;
    assign dec_pc    = dec_pc_q;
    assign dec_tag   = dec_tag_q;
    assign rs_issue  = rs_issue_q;
    assign lsb_issue = lsb_issue_q;

endmodule
`default_nettype wire
